rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares the single puzzle-input ROM (8-bit data, N_ADDR_BITS+1 address bits, registered read) between N_REQ independent parser/solver engines.
- Grants at most one read per cycle using round-robin priority, so one engine can prefetch part-2 data while another streams part-1 data.
- Tracks in-flight reads in a tag pipeline and returns each byte, plus its end-of-file flag, to the requester that issued it.
- Sits between the ROM and the solver cores inside the top-level core.

Parameters:
- N_ADDR_BITS, 16, ROM address is N_ADDR_BITS+1 bits wide.
- N_REQ, 2, number of requesters (2..8).
- ROM_LATENCY, 1, cycles from ROM address sample edge to rom_data/rom_valid being stable.
- CNT_WIDTH, 32, width of the grant counter.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester read request; held until granted.
- req_addr  in  N_REQ*(N_ADDR_BITS+1)  flattened addresses; slice i belongs to requester i.
- gnt  out  N_REQ  one-hot, combinational; request i is accepted this cycle.
- rom_addr  out  N_ADDR_BITS+1  combinational mux of the granted address; 0 when no grant.
- rom_data  in  8  ROM read data.
- rom_valid  in  1  ROM flag; high when the address lies inside the loaded file.
- rsp_valid  out  1  registered response strobe.
- rsp_id  out  $clog2(N_REQ) (min 1)  index of the requester owning the response.
- rsp_data  out  8  returned byte.
- rsp_eof  out  1  equals !rom_valid for that read.
- busy  out  1  high while any read is in flight.
- grant_count  out  CNT_WIDTH  total accepted reads since reset; saturates at all-ones.

Behaviour:
- Reset state: gnt=0 (forced, even if req is high), rom_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_eof=0, busy=0, grant_count=0, round-robin pointer=0, tag pipeline cleared.
- Arbitration:
  - The pointer names the highest-priority requester.
  - The grant goes to the first asserted req searching pointer, pointer+1, … modulo N_REQ.
  - On a grant to i, the pointer becomes (i+1) mod N_REQ at the next edge; with no grant it holds.
  - A lone requester receives back-to-back grants every cycle.
- Handshake:
  - A transfer occurs when req[i] && gnt[i] at a rising edge.
  - The requester may change req_addr or drop req only after that edge.
  - Dropping req before grant is legal and cancels the request with no side effect.
- Tag pipeline:
  - ROM_LATENCY+1 stages of {valid, id}.
  - Stage 0 loads {1, granted id} on a transfer, otherwise {0, x}.
- Latency:
  - Grant in cycle t means rom_data/rom_valid are sampled by the arbiter at the end of cycle t+ROM_LATENCY.
  - rsp_* are visible during cycle t+ROM_LATENCY+1. Default: 2 cycles after the grant cycle.
- rsp_valid is a single-cycle strobe per transfer. Fully pipelined: one response per cycle sustained, in grant order.
- rsp_data/rsp_eof/rsp_id hold their last values when rsp_valid=0.
- busy = OR of the tag-pipeline valid bits.
- grant_count increments by 1 per transfer; it does not wrap past 2^CNT_WIDTH-1.
- Address width: rom_addr is passed unmodified. The arbiter does not interpret the address; out-of-range reads return rsp_eof=1.
- Reset mid-operation: in-flight reads are discarded. No rsp_valid appears in any cycle after rst is sampled high. The pointer returns to 0.
- Simultaneous request and response in the same cycle is normal pipelined operation; no stall.
- There is no back-pressure on the response side; requesters must always accept rsp_valid.

Test Plan:
- Single requester: req[0] held high, addresses 0,1,2,3 presented on each grant → gnt[0] high 4 consecutive cycles; rsp_valid 2 cycles after each grant; rsp_data = ROM bytes 0..3; rsp_id=0; grant_count=4.
- Two contenders from reset: req=2'b11, addr0=10, addr1=20, both held through 4 grants → grant order 0,1,0,1; responses ids 0,1,0,1 with bytes at 10,20,10,20 in that order.
- Fairness after idle: grant to 1, then idle 3 cycles, then req=2'b11 → next grant goes to 0 (pointer=0); the one after goes to 1.
- EOF: request address = file length and file length+5 → rsp_eof=1 on both; a request at file length-1 gives rsp_eof=0 with the last byte.
- Reset mid-flight: grant in cycle t, assert rst in cycle t+1 for 1 cycle → rsp_valid stays 0 through t+5; busy=0 and grant_count=0 after reset; gnt=0 during rst even with req=2'b11.
- Saturation (CNT_WIDTH=3): 10 consecutive grants → grant_count reaches 7 and holds.

Source files
------------

// File: rtl/rom_read_arbiter_if.sv
// Requester-side bus of the ROM read arbiter: request/grant handshake plus
// the shared, tagged response channel.
interface rom_read_arbiter_if #(
  parameter int N_REQ       = 2,
  parameter int N_ADDR_BITS = 16
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: a read transfers when req[i] && gnt[i] at a rising edge. The
  // requester holds req[i] and its req_addr slice stable until that edge and
  // may drop req earlier to cancel. Responses have no back-pressure: rsp_valid
  // is a one-cycle strobe that the owner named by rsp_id must accept.
  logic [N_REQ-1:0]                 req;
  logic [N_REQ*(N_ADDR_BITS+1)-1:0] req_addr;
  logic [N_REQ-1:0]                 gnt;
  logic                             rsp_valid;
  logic [ID_W-1:0]                  rsp_id;
  logic [7:0]                       rsp_data;
  logic                             rsp_eof;

  modport master (
    output req, req_addr,
    input  gnt, rsp_valid, rsp_id, rsp_data, rsp_eof
  );

  modport slave (
    input  req, req_addr,
    output gnt, rsp_valid, rsp_id, rsp_data, rsp_eof
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one registered-read puzzle ROM between N_REQ
// engines; a {valid,id} tag pipeline routes each returned byte to its owner.
module rom_read_arbiter #(
  parameter int N_ADDR_BITS = 16,
  parameter int N_REQ       = 2,
  parameter int ROM_LATENCY = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  rom_read_arbiter_if.slave      bus,
  output logic [N_ADDR_BITS:0]   rom_addr,
  input  logic [7:0]             rom_data,
  input  logic                   rom_valid,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   grant_count
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW   = N_ADDR_BITS + 1;

  logic [ID_W-1:0]    ptr;
  logic               found;
  logic [ID_W-1:0]    gnt_idx;
  logic [N_REQ-1:0]   gnt_c;
  logic [ROM_LATENCY:0] tag_v;
  logic [ID_W-1:0]    tag_id [0:ROM_LATENCY];

  // Search from the pointer upwards; the first asserted request wins.
  always_comb begin
    int cand;
    cand    = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
    if (rst) found = 1'b0;
    gnt_c = '0;
    if (found) gnt_c[gnt_idx] = 1'b1;
  end

  assign bus.gnt   = gnt_c;
  assign rom_addr  = found ? bus.req_addr[gnt_idx*AW +: AW] : '0;
  assign busy      = |tag_v;
  // The last tag stage lines up with the registered response fields.
  assign bus.rsp_valid = tag_v[ROM_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      tag_v        <= '0;
      for (int s = 0; s <= ROM_LATENCY; s++) tag_id[s] <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_data <= '0;
      bus.rsp_eof  <= 1'b0;
      grant_count  <= '0;
    end else begin
      if (found)
        ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      tag_v[0]  <= found;
      tag_id[0] <= gnt_idx;
      for (int s = 1; s <= ROM_LATENCY; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      // ROM output is stable in the cycle the second-to-last stage is valid.
      if (tag_v[ROM_LATENCY-1]) begin
        bus.rsp_data <= rom_data;
        bus.rsp_id   <= tag_id[ROM_LATENCY-1];
        bus.rsp_eof  <= !rom_valid;
      end
      if (found && grant_count != '1)
        grant_count <= grant_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: a 40-byte file in a 1-cycle ROM whose
// byte at address a is (7*a+3) mod 256; grant counter narrowed to 3 bits.
module tb_rom_read_arbiter;
  localparam int FILE_LEN = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic        rom_valid = 1'b0;
  logic        busy;
  logic [2:0]  grant_count;

  int n_vec = 0;
  int n_err = 0;

  rom_read_arbiter_if #(.N_REQ(2), .N_ADDR_BITS(16)) bus ();

  rom_read_arbiter #(
    .N_ADDR_BITS(16), .N_REQ(2), .ROM_LATENCY(1), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_valid(rom_valid),
    .busy(busy), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  // Registered-read ROM model
  always @(posedge clk) begin
    rom_data  <= 8'(rom_addr * 17'd7 + 17'd3);
    rom_valid <= (rom_addr < 17'(FILE_LEN));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle.
  task automatic cyc(input logic r, input logic [1:0] rq, input logic [16:0] a0, input logic [16:0] a1);
    @(negedge clk);
    rst          = r;
    bus.req      = rq;
    bus.req_addr = {a1, a0};
    #1;
  endtask

  logic [7:0] exp_t1 [0:3] = '{8'd3, 8'd10, 8'd17, 8'd24};
  logic [7:0] exp_t2 [0:1] = '{8'd73, 8'd143};

  initial begin
    bus.req      = '0;
    bus.req_addr = '0;

    // Reset: grants forced off even with both requests up
    cyc(1'b1, 2'b11, 17'd0, 17'd0);
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_rom_addr", rom_addr, 17'd0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 8'd0);
    chk("rst_rsp_eof", bus.rsp_eof, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", grant_count, 3'd0);

    // Single requester streaming addresses 0..3
    for (int i = 0; i <= 6; i++) begin
      cyc(1'b0, (i < 4) ? 2'b01 : 2'b00, 17'(i), 17'd0);
      chk("t1_gnt", bus.gnt, (i < 4) ? 2'b01 : 2'b00);
      if (i < 4) chk("t1_rom_addr", rom_addr, 17'(i));
      chk("t1_rsp_valid", bus.rsp_valid, (i >= 2 && i < 6));
      if (i >= 2 && i < 6) begin
        chk("t1_rsp_data", bus.rsp_data, exp_t1[i-2]);
        chk("t1_rsp_id", bus.rsp_id, 1'b0);
        chk("t1_rsp_eof", bus.rsp_eof, 1'b0);
      end
      chk("t1_busy", busy, (i >= 1 && i <= 5));
      chk("t1_count", grant_count, (i < 4) ? i : 4);
    end
    chk("t1_hold_data", bus.rsp_data, 8'd24);

    // Two contenders from reset: alternate 0,1,0,1
    cyc(1'b1, 2'b00, 17'd0, 17'd0);
    for (int i = 0; i <= 5; i++) begin
      cyc(1'b0, (i < 4) ? 2'b11 : 2'b00, 17'd10, 17'd20);
      chk("t2_gnt", bus.gnt, (i >= 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10));
      if (i < 4) chk("t2_rom_addr", rom_addr, (i % 2 == 0) ? 17'd10 : 17'd20);
      chk("t2_rsp_valid", bus.rsp_valid, (i >= 2));
      if (i >= 2) begin
        chk("t2_rsp_id", bus.rsp_id, i % 2);
        chk("t2_rsp_data", bus.rsp_data, exp_t2[i % 2]);
      end
    end
    chk("t2_count", grant_count, 3'd4);

    // Fairness after idle: pointer parked at 0 following a grant to 1
    cyc(1'b0, 2'b01, 17'd5, 17'd0);
    chk("t3_gnt_a", bus.gnt, 2'b01);
    cyc(1'b0, 2'b10, 17'd0, 17'd6);
    chk("t3_gnt_b", bus.gnt, 2'b10);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 17'd0, 17'd0);
    chk("t3_idle_busy", busy, 1'b0);
    cyc(1'b0, 2'b11, 17'd7, 17'd8);
    chk("t3_gnt_first", bus.gnt, 2'b01);
    chk("t3_addr_first", rom_addr, 17'd7);
    cyc(1'b0, 2'b11, 17'd7, 17'd8);
    chk("t3_gnt_second", bus.gnt, 2'b10);
    chk("t3_addr_second", rom_addr, 17'd8);
    cyc(1'b0, 2'b00, 17'd0, 17'd0);
    chk("t3_rsp0_valid", bus.rsp_valid, 1'b1);
    chk("t3_rsp0_id", bus.rsp_id, 1'b0);
    chk("t3_rsp0_data", bus.rsp_data, 8'd52);
    cyc(1'b0, 2'b00, 17'd0, 17'd0);
    chk("t3_rsp1_valid", bus.rsp_valid, 1'b1);
    chk("t3_rsp1_id", bus.rsp_id, 1'b1);
    chk("t3_rsp1_data", bus.rsp_data, 8'd59);

    // End of file: addresses 40, 45 past the end; 39 is the last byte
    cyc(1'b0, 2'b01, 17'd40, 17'd0);
    cyc(1'b0, 2'b01, 17'd45, 17'd0);
    cyc(1'b0, 2'b01, 17'd39, 17'd0);
    chk("t4_eof40_valid", bus.rsp_valid, 1'b1);
    chk("t4_eof40", bus.rsp_eof, 1'b1);
    cyc(1'b0, 2'b00, 17'd0, 17'd0);
    chk("t4_eof45_valid", bus.rsp_valid, 1'b1);
    chk("t4_eof45", bus.rsp_eof, 1'b1);
    cyc(1'b0, 2'b00, 17'd0, 17'd0);
    chk("t4_last_valid", bus.rsp_valid, 1'b1);
    chk("t4_last_eof", bus.rsp_eof, 1'b0);
    chk("t4_last_data", bus.rsp_data, 8'd20);

    // Reset while a read is in flight
    cyc(1'b1, 2'b00, 17'd0, 17'd0);
    cyc(1'b0, 2'b11, 17'd1, 17'd2);
    chk("t5_gnt", bus.gnt, 2'b01);
    cyc(1'b1, 2'b11, 17'd1, 17'd2);
    chk("t5_gnt_in_rst", bus.gnt, 2'b00);
    chk("t5_rom_addr_in_rst", rom_addr, 17'd0);
    chk("t5_busy_inflight", busy, 1'b1);
    chk("t5_count_inflight", grant_count, 3'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 2'b00, 17'd0, 17'd0);
      chk("t5_no_rsp", bus.rsp_valid, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_count", grant_count, 3'd0);
    end

    // Counter saturation at 7 over 10 grants
    cyc(1'b1, 2'b00, 17'd0, 17'd0);
    for (int i = 0; i <= 10; i++) begin
      cyc(1'b0, (i < 10) ? 2'b01 : 2'b00, 17'(i), 17'd0);
      chk("t6_count", grant_count, (i < 7) ? i : 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
